// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus between the two requesters, the arbiter and the
// register-file write port.
//
// Handshake: a requester raises *_valid with *_rd/*_wd and holds all
// three stable until it sees *_ready high. A write is transferred on a
// rising edge where valid && ready. Ready never rises without the
// matching valid, and at most one side is ready in any cycle.
// wr/rd/wd is the registered write port seen by the register file.
interface regfile_wb_arbiter_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  a_valid;
  logic                  a_ready;
  logic [4:0]            a_rd;
  logic [DATA_WIDTH-1:0] a_wd;

  logic                  b_valid;
  logic                  b_ready;
  logic [4:0]            b_rd;
  logic [DATA_WIDTH-1:0] b_wd;

  logic                  wr;
  logic [4:0]            rd;
  logic [DATA_WIDTH-1:0] wd;

  // Requesters and register-file side.
  modport master (
    output a_valid, a_rd, a_wd,
    output b_valid, b_rd, b_wd,
    input  a_ready, b_ready,
    input  wr, rd, wd
  );

  // Arbiter side.
  modport slave (
    input  a_valid, a_rd, a_wd,
    input  b_valid, b_rd, b_wd,
    output a_ready, b_ready,
    output wr, rd, wd
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Register-file writeback arbiter. A (ALU result) has fixed priority over
// B (load data); a starvation counter forces a B grant once B has lost
// STARVE_LIMIT consecutive cycles. The winning write is registered and
// presented to the register file one cycle after the accept edge. A
// read-after-write query lets decode stall on the write still in flight.
module regfile_wb_arbiter #(
  parameter int DATA_WIDTH   = 32,
  parameter int STARVE_LIMIT = 3,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  regfile_wb_arbiter_if.slave  bus,
  input  logic [4:0]           q_rs1,
  input  logic [4:0]           q_rs2,
  output logic                 q_stall,
  output logic [CNT_WIDTH-1:0] conflict_cnt
);

  // STARVE_LIMIT is 1..15, so four bits always hold it.
  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);
  localparam logic [CNT_WIDTH-1:0] CNT_SAT = {CNT_WIDTH{1'b1}};

  logic [3:0]            starve;
  logic                  starved;
  logic                  grant_a;
  logic                  grant_b;
  logic                  xfer;
  logic [4:0]            sel_rd;
  logic [DATA_WIDTH-1:0] sel_wd;

  logic                  wr_q;
  logic [4:0]            rd_q;
  logic [DATA_WIDTH-1:0] wd_q;

  assign starved = (starve == STARVE_MAX);

  // Grant: starved B first, then A, then B. Nothing is granted in reset.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (!rst) begin
      if (bus.b_valid && starved) begin
        grant_b = 1'b1;
      end else if (bus.a_valid) begin
        grant_a = 1'b1;
      end else if (bus.b_valid) begin
        grant_b = 1'b1;
      end
    end
  end

  // Grants only ever assert with their valid, so a grant is a transfer.
  assign xfer        = grant_a | grant_b;
  assign bus.a_ready = grant_a;
  assign bus.b_ready = grant_b;

  // Steer the winning destination and data toward the output register.
  always_comb begin
    sel_rd = bus.a_rd;
    sel_wd = bus.a_wd;
    if (grant_b) begin
      sel_rd = bus.b_rd;
      sel_wd = bus.b_wd;
    end
  end

  // Output register: one-cycle latency. x0 writes complete the handshake
  // but never raise wr; rd/wd keep their last value when idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= 1'b0;
      rd_q <= 5'd0;
      wd_q <= '0;
    end else begin
      wr_q <= xfer && (sel_rd != 5'd0);
      if (xfer) begin
        rd_q <= sel_rd;
        wd_q <= sel_wd;
      end
    end
  end

  // A write accepted just before reset must not commit while reset is
  // held, so the enable is masked by rst as well as cleared by it.
  assign bus.wr = wr_q & ~rst;
  assign bus.rd = rd_q;
  assign bus.wd = wd_q;

  // Starvation counter: counts consecutive cycles B waits, saturating.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve <= 4'd0;
    end else if (!bus.b_valid || grant_b) begin
      starve <= 4'd0;
    end else if (!starved) begin
      starve <= starve + 4'd1;
    end
  end

  // Conflict statistics: cycles with both requesters valid, saturating.
  always_ff @(posedge clk) begin
    if (rst) begin
      conflict_cnt <= '0;
    end else if (bus.a_valid && bus.b_valid && (conflict_cnt != CNT_SAT)) begin
      conflict_cnt <= conflict_cnt + 1'b1;
    end
  end

  // Hazard query against the write currently on the port; x0 never hits.
  always_comb begin
    q_stall = 1'b0;
    if (bus.wr && (bus.rd != 5'd0) &&
        ((q_rs1 == bus.rd) || (q_rs2 == bus.rd))) begin
      q_stall = 1'b1;
    end
  end

endmodule
